// File: rtl/alu_pkg.sv
// Shared opcode, flag and state definitions for the generated ALUs and their command issuer.
package alu_pkg;

    localparam logic [3:0] OP_XNOR  = 4'd0;
    localparam logic [3:0] OP_SGE   = 4'd1;
    localparam logic [3:0] OP_SGT   = 4'd2;
    localparam logic [3:0] OP_SLL   = 4'd3;
    localparam logic [3:0] OP_PASSB = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_SNE   = 4'd6;
    localparam logic [3:0] OP_NOR   = 4'd7;

    localparam logic [15:0] OP_SUPPORTED_DEFAULT = 16'h00B9;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_cmd_issuer.sv
// Command front end for a combinational ALU: registers the operation onto the ALU port,
// waits SETTLE cycles, then holds a tagged result/flags response until it is consumed.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned OPW    = 4,
    parameter int unsigned SHW    = 5,
    parameter int unsigned TAGW   = 4,
    parameter int unsigned SETTLE = 1,
    parameter logic [2**OPW-1:0] OP_SUPPORTED = OP_SUPPORTED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SHW-1:0]   cmd_shift,
    input  logic [TAGW-1:0]  cmd_tag,

    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [SHW-1:0]   alu_shift,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_overflow,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [TAGW-1:0]  rsp_tag,
    output logic             rsp_err,

    output logic             busy,
    output logic [7:0]       err_count
);

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

    state_e           r_state;
    logic             r_out_of_rst;
    logic [3:0]       r_cnt;
    logic [OPW-1:0]   r_alu_opcode;
    logic [WIDTH-1:0] r_alu_input1;
    logic [WIDTH-1:0] r_alu_input2;
    logic [SHW-1:0]   r_alu_shift;
    logic [WIDTH-1:0] r_rsp_result;
    logic [2:0]       r_rsp_flags;
    logic [TAGW-1:0]  r_rsp_tag;
    logic             r_rsp_err;
    logic [7:0]       r_err_count;

    logic w_accept;
    logic w_supported;

    // cmd_ready stays low while reset is asserted, rising on the first clock after release.
    assign cmd_ready   = r_out_of_rst && (r_state == ST_IDLE);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_supported = OP_SUPPORTED[cmd_opcode];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_out_of_rst <= 1'b0;
            r_cnt        <= '0;
            r_alu_opcode <= '0;
            r_alu_input1 <= '0;
            r_alu_input2 <= '0;
            r_alu_shift  <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_out_of_rst <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rsp_tag <= cmd_tag;
                        if (w_supported) begin
                            r_alu_opcode <= cmd_opcode;
                            r_alu_input1 <= cmd_a;
                            r_alu_input2 <= cmd_b;
                            r_alu_shift  <= cmd_shift;
                            r_cnt        <= LP_SETTLE;
                            r_state      <= ST_WAIT;
                        end else begin
                            // Unsupported ops never reach the ALU; answer directly with an error.
                            r_rsp_result <= '0;
                            r_rsp_flags  <= '0;
                            r_rsp_err    <= 1'b1;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                            r_state      <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_rsp_result            <= alu_result;
                        r_rsp_flags[FLAG_ZERO]  <= alu_zero;
                        r_rsp_flags[FLAG_CARRY] <= alu_carry;
                        r_rsp_flags[FLAG_OVF]   <= alu_overflow;
                        r_rsp_err               <= 1'b0;
                        r_state                 <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_opcode = r_alu_opcode;
    assign alu_input1 = r_alu_input1;
    assign alu_input2 = r_alu_input2;
    assign alu_shift  = r_alu_shift;
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != ST_IDLE);
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized bench for alu_cmd_issuer: two issuers (SETTLE=1 and SETTLE=4), each driving a
// behavioural 128-bit ALU, checked against a transaction-level model of the command protocol.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int W = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         c_valid [2];
    logic         c_ready [2];
    logic [3:0]   c_op    [2];
    logic [W-1:0] c_a     [2];
    logic [W-1:0] c_b     [2];
    logic [4:0]   c_sh    [2];
    logic [3:0]   c_tag   [2];
    logic [3:0]   a_op    [2];
    logic [W-1:0] a_in1   [2];
    logic [W-1:0] a_in2   [2];
    logic [4:0]   a_sh    [2];
    logic [W-1:0] a_res   [2];
    logic         a_c     [2];
    logic         a_z     [2];
    logic         a_o     [2];
    logic         r_valid [2];
    logic         r_ready [2];
    logic [W-1:0] r_res   [2];
    logic [2:0]   r_flags [2];
    logic [3:0]   r_tag   [2];
    logic         r_err   [2];
    logic         busy    [2];
    logic [7:0]   ecnt    [2];

    // Model state: last operation actually driven onto each ALU port, and error counters.
    logic [3:0]   m_op  [2];
    logic [W-1:0] m_in1 [2];
    logic [W-1:0] m_in2 [2];
    logic [4:0]   m_sh  [2];
    int           m_err [2];

    int checks = 0;
    int errors = 0;

    alu_cmd_issuer #(.WIDTH(128), .OPW(4), .SHW(5), .TAGW(4), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c_valid[0]), .cmd_ready(c_ready[0]), .cmd_opcode(c_op[0]),
        .cmd_a(c_a[0]), .cmd_b(c_b[0]), .cmd_shift(c_sh[0]), .cmd_tag(c_tag[0]),
        .alu_opcode(a_op[0]), .alu_input1(a_in1[0]), .alu_input2(a_in2[0]), .alu_shift(a_sh[0]),
        .alu_result(a_res[0]), .alu_carry(a_c[0]), .alu_zero(a_z[0]), .alu_overflow(a_o[0]),
        .rsp_valid(r_valid[0]), .rsp_ready(r_ready[0]), .rsp_result(r_res[0]),
        .rsp_flags(r_flags[0]), .rsp_tag(r_tag[0]), .rsp_err(r_err[0]),
        .busy(busy[0]), .err_count(ecnt[0])
    );

    alu_cmd_issuer #(.WIDTH(128), .OPW(4), .SHW(5), .TAGW(4), .SETTLE(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c_valid[1]), .cmd_ready(c_ready[1]), .cmd_opcode(c_op[1]),
        .cmd_a(c_a[1]), .cmd_b(c_b[1]), .cmd_shift(c_sh[1]), .cmd_tag(c_tag[1]),
        .alu_opcode(a_op[1]), .alu_input1(a_in1[1]), .alu_input2(a_in2[1]), .alu_shift(a_sh[1]),
        .alu_result(a_res[1]), .alu_carry(a_c[1]), .alu_zero(a_z[1]), .alu_overflow(a_o[1]),
        .rsp_valid(r_valid[1]), .rsp_ready(r_ready[1]), .rsp_result(r_res[1]),
        .rsp_flags(r_flags[1]), .rsp_tag(r_tag[1]), .rsp_err(r_err[1]),
        .busy(busy[1]), .err_count(ecnt[1])
    );

    // Behavioural ALU: returns {overflow, carry, zero, result}.
    function automatic logic [W+2:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [4:0] sh);
        logic [W-1:0] r;
        logic c, o;
        r = '0;
        case (op)
            OP_XNOR:  r = ~(a ^ b);
            OP_SGE:   r[0] = ($signed(a) >= $signed(b));
            OP_SGT:   r[0] = ($signed(a) > $signed(b));
            OP_SLL:   r = a << sh;
            OP_PASSB: r = b;
            OP_SRL:   r = a >> sh;
            OP_SNE:   r[0] = (a != b);
            OP_NOR:   r = ~(a | b);
            default:  r = '0;
        endcase
        c = a[W-1] ^ b[0];
        o = (^a[7:0]) ^ b[W-1];
        return {o, c, (r == '0), r};
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            {a_o[d], a_c[d], a_z[d], a_res[d]} = alu_fn(a_op[d], a_in1[d], a_in2[d], a_sh[d]);
        end
    end

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_op[d] = '0; m_in1[d] = '0; m_in2[d] = '0; m_sh[d] = '0; m_err[d] = 0;
        end
    endtask

    task automatic issue(input int d, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh, input logic [3:0] tag);
        int n = 0;
        @(negedge clk);
        c_op[d] = op; c_a[d] = a; c_b[d] = b; c_sh[d] = sh; c_tag[d] = tag;
        c_valid[d] = 1'b1;
        while (!c_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", W'(n < 100), W'(1));
        @(posedge clk);
        #1 c_valid[d] = 1'b0;
    endtask

    // Called right after the accept edge; returns at the first sample that sees rsp_valid.
    task automatic expect_rsp(input int d, input logic [3:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [4:0] sh, input logic [3:0] tag);
        logic         sup;
        logic [W+2:0] e;
        int           lat;
        int           n = 0;
        sup = op inside {OP_XNOR, OP_SLL, OP_PASSB, OP_SRL, OP_NOR};
        lat = sup ? settle_of(d) + 1 : 1;
        e   = sup ? alu_fn(op, a, b, sh) : '0;
        if (sup) begin
            m_op[d] = op; m_in1[d] = a; m_in2[d] = b; m_sh[d] = sh;
        end else if (m_err[d] < 255) begin
            m_err[d]++;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!r_valid[d] && n < 40);
        check("rsp_latency", W'(n), W'(lat));
        check("rsp_result", r_res[d], e[W-1:0]);
        check("rsp_flags", W'(r_flags[d]), W'(e[W+2:W]));
        check("rsp_tag", W'(r_tag[d]), W'(tag));
        check("rsp_err", W'(r_err[d]), W'(!sup));
        check("err_count", W'(ecnt[d]), W'(m_err[d]));
        check("cmd_ready_resp", W'(c_ready[d]), W'(0));
        check("alu_op", W'(a_op[d]), W'(m_op[d]));
        check("alu_in1", a_in1[d], m_in1[d]);
        check("alu_in2", a_in2[d], m_in2[d]);
        check("alu_shift", W'(a_sh[d]), W'(m_sh[d]));
    endtask

    task automatic release_rsp(input int d);
        r_ready[d] = 1'b1;
        @(negedge clk);
        check("rsp_valid_after_R", W'(r_valid[d]), W'(0));
        check("cmd_ready_after_R", W'(c_ready[d]), W'(1));
        check("busy_after_R", W'(busy[d]), W'(0));
        r_ready[d] = 1'b0;
    endtask

    task automatic run(input int d, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] sh, input logic [3:0] tag,
                       input logic early);
        issue(d, op, a, b, sh, tag);
        if (early) r_ready[d] = 1'b1;
        expect_rsp(d, op, a, b, sh, tag);
        release_rsp(d);
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [W-1:0] sr, s1, ra, rb, one;
        logic [3:0]   st, rop;
        logic         stable, seen;
        int           d;

        for (int i = 0; i < 2; i++) begin
            c_valid[i] = 1'b0; c_op[i] = '0; c_a[i] = '0; c_b[i] = '0;
            c_sh[i] = '0; c_tag[i] = '0; r_ready[i] = 1'b0;
        end
        model_reset();

        #2;
        for (int i = 0; i < 2; i++) begin
            check("rst_cmd_ready", W'(c_ready[i]), W'(0));
            check("rst_rsp_valid", W'(r_valid[i]), W'(0));
            check("rst_busy", W'(busy[i]), W'(0));
            check("rst_alu_in1", a_in1[i], '0);
            check("rst_rsp_result", r_res[i], '0);
            check("rst_err_count", W'(ecnt[i]), W'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_out_of_rst", W'(c_ready[0]), W'(1));

        issue(0, OP_XNOR, '0, '0, 5'd0, 4'd3);
        expect_rsp(0, OP_XNOR, '0, '0, 5'd0, 4'd3);
        check("xnor_all_ones", r_res[0], {W{1'b1}});
        check("xnor_zero_flag", W'(r_flags[0][FLAG_ZERO]), W'(0));
        release_rsp(0);

        one = W'(1);
        issue(0, OP_SLL, one, '0, 5'd31, 4'd6);
        expect_rsp(0, OP_SLL, one, '0, 5'd31, 4'd6);
        check("sll_1_31", r_res[0], W'(64'h8000_0000));
        release_rsp(0);

        run(0, OP_PASSB, rnd_word(), '0, 5'd2, 4'd7, 1'b0);
        issue(0, OP_SGE, rnd_word(), rnd_word(), 5'd1, 4'd8);
        expect_rsp(0, OP_SGE, c_a[0], c_b[0], 5'd1, 4'd8);
        check("sge_err_count", W'(ecnt[0]), W'(1));
        release_rsp(0);

        // Response back-pressure with a second command waiting.
        ra = rnd_word(); rb = rnd_word();
        issue(0, OP_NOR, ra, rb, 5'd0, 4'd5);
        expect_rsp(0, OP_NOR, ra, rb, 5'd0, 4'd5);
        sr = r_res[0]; st = r_tag[0]; s1 = a_in1[0];
        c_op[0] = OP_XNOR; c_a[0] = rb; c_b[0] = ra; c_sh[0] = 5'd0; c_tag[0] = 4'd9;
        c_valid[0] = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (r_res[0] !== sr || r_tag[0] !== st || !r_valid[0] || c_ready[0] || a_in1[0] !== s1)
                stable = 1'b0;
        end
        check("hold_stable", W'(stable), W'(1));
        release_rsp(0);
        @(posedge clk);
        #1 c_valid[0] = 1'b0;
        expect_rsp(0, OP_XNOR, rb, ra, 5'd0, 4'd9);
        release_rsp(0);

        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(0, 1));
            rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
            run(d, rop, rnd_word(), rnd_word(), 5'($urandom_range(0, 31)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 260; i++) begin
            rop = 4'($urandom_range(8, 15));
            run(0, rop, rnd_word(), rnd_word(), 5'd0, 4'(i), 1'b1);
        end
        check("err_count_saturated", W'(ecnt[0]), W'(255));

        ra = '0; ra[W-1] = 1'b1;
        issue(1, OP_SRL, ra, '0, 5'd4, 4'd2);
        expect_rsp(1, OP_SRL, ra, '0, 5'd4, 4'd2);
        check("srl_settle4", r_res[1], {8'h08, 120'h0});
        release_rsp(1);

        // Reset during WAIT discards the pending command.
        issue(1, OP_XNOR, rnd_word(), rnd_word(), 5'd0, 4'd11);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_busy", W'(busy[1]), W'(0));
        check("midrst_rsp_valid", W'(r_valid[1]), W'(0));
        check("midrst_cmd_ready", W'(c_ready[1]), W'(0));
        check("midrst_alu_in1", a_in1[1], '0);
        check("midrst_err_count0", W'(ecnt[0]), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (r_valid[1] || busy[1]) seen = 1'b1;
        end
        check("no_rsp_after_rst", W'(seen), W'(0));
        run(1, OP_SLL, rnd_word(), rnd_word(), 5'd9, 4'd12, 1'b0);
        run(0, OP_SGT, rnd_word(), rnd_word(), 5'd0, 4'd13, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Initiator-side front end for the generated combinational ALUs. Accepts operation commands on a valid/ready stream, registers and drives opcode, operands and shift amount onto an ALU port, waits a fixed settle time, then captures result and flags into a tagged response held until the consumer takes it. Sits between the command source (sequencer or bench) and any generated ALU instance; one command outstanding at a time.

## Interface
- WIDTH, 128, operand/result width
- OPW, 4, opcode width
- SHW, 5, shift-amount width
- TAGW, 4, command tag width
- SETTLE, 1, cycles between ALU drive and result sample; legal range 1..15
- OP_SUPPORTED, 16'h00B9, bit n set = opcode n is implemented by the attached ALU (default: 0,3,4,5,7)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can accept
- cmd_opcode  in  OPW  operation
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_shift  in  SHW  shift amount
- cmd_tag  in  TAGW  returned with response
- alu_opcode  out  OPW  registered drive to ALU
- alu_input1  out  WIDTH  registered drive to ALU
- alu_input2  out  WIDTH  registered drive to ALU
- alu_shift  out  SHW  registered drive to ALU
- alu_result  in  WIDTH  ALU result
- alu_carry, alu_zero, alu_overflow  in  1 each  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_result  out  WIDTH  captured result
- rsp_flags  out  3  {overflow, carry, zero}
- rsp_tag  out  TAGW  tag of the command
- rsp_err  out  1  opcode unsupported; result/flags forced 0
- busy  out  1  state != IDLE
- err_count  out  8  unsupported-opcode count, saturates at 255

## Operation
- FSM states IDLE, WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid: capture cmd_tag. If OP_SUPPORTED[cmd_opcode]: load alu_* regs from cmd_*, load settle counter with SETTLE, go WAIT. Else: alu_* regs unchanged (unsupported ops are never driven to the ALU; their result is undefined), rsp_result=0, rsp_flags=0, rsp_err=1, err_count+1 (saturating), go RESP.
- WAIT: counter decrements each cycle; on the edge where counter==1, sample alu_result and all three flags into rsp_*, rsp_err=0, go RESP.
- RESP: rsp_valid=1, rsp_* stable. On rsp_ready go IDLE.
- cmd_ready=0 in WAIT and RESP; cmd_valid ignored there.
- alu_* regs hold last issued values after completion (no return to zero).
- rsp_flags taken verbatim from ALU; no recomputation.

## Timing
- Reset (async assert, sync deassert by clk domain): state IDLE, cmd_ready=1 once out of reset, rsp_valid=0, busy=0, all alu_*, rsp_*, err_count = 0.
- Accept edge E (cmd_valid & cmd_ready). Supported: alu_* valid after E; sample at edge E+SETTLE; rsp_valid high after E+SETTLE. Unsupported: rsp_valid high after E.
- Response handshake edge R: rsp_valid low and cmd_ready high after R; next accept earliest at R+1. Peak throughput one op per SETTLE+2 cycles.
- rsp_ready held high before rsp_valid: no effect until RESP.
- Reset mid-WAIT or mid-RESP: command and pending response discarded, no response emitted.
- err_count at 255 stays 255.

## Structure
- Shared package alu_pkg: opcode constants (XNOR=0, SGE=1, SGT=2, SLL=3, PASSB=4, SRL=5, SNE=6, NOR=7), default OP_SUPPORTED mask, flag bit indices (ZERO=0, CARRY=1, OVF=2), state enum.
- Single module; no sub-module. Bench instantiates a generated 128-bit ALU as the partner on the alu_* port.

## Test plan
- XNOR, a=0, b=0, tag=3, SETTLE=1 -> rsp after E+1: result all ones, zero=0, tag=3, err=0.
- SLL a=1, shift=31 -> result=1<<31; PASSB b=0 -> result=0, zero=1.
- Opcode 1 (SGE) -> rsp_valid after E, err=1, result=0, alu_* unchanged, err_count=1; 260 such ops -> err_count=255.
- rsp_ready held low 20 cycles with cmd_valid high -> rsp_* stable, cmd_ready=0, no second accept; release -> next accept at R+1.
- SETTLE=4, SRL a=128'h8000…0, shift=4 -> rsp_valid first high after E+4, result=128'h0800…0.
- rst_n pulsed low during WAIT -> all outputs 0 immediately, no response after release, next command completes normally.
